// File: rtl/i2c_init_sequencer_if.sv
// Table, status and I2C pad signals of the init sequencer.
// The master modport is the sequencer; the slave modport is its environment (ROM, pads, i2c_0).
interface i2c_init_sequencer_if #(
  parameter int IDX_W = 8
);
  logic             start;
  logic [IDX_W-1:0] tbl_idx;
  logic [7:0]       tbl_reg;
  logic [7:0]       tbl_data;
  logic             busy;
  logic             done;
  logic             nack_err;
  logic             sda_in;
  logic             scl_in;
  logic             nios_sda_oe;
  logic             nios_scl_oe;
  logic             sda_oe;
  logic             scl_oe;

  modport master (
    input  start, tbl_reg, tbl_data, sda_in, scl_in, nios_sda_oe, nios_scl_oe,
    output tbl_idx, busy, done, nack_err, sda_oe, scl_oe
  );

  modport slave (
    output start, tbl_reg, tbl_data, sda_in, scl_in, nios_sda_oe, nios_scl_oe,
    input  tbl_idx, busy, done, nack_err, sda_oe, scl_oe
  );
endinterface

// File: rtl/i2c_init_sequencer.sv
// I2C master that writes a (register, value) table to one slave, sharing the pads with i2c_0.
// Define CLOCK_STRETCH_EN to let a slave stretch SCL during the high phase of each bit.
module i2c_init_sequencer #(
  parameter int         CLK_HZ      = 50000000,
  parameter int         I2C_HZ      = 100000,
  parameter logic [6:0] SLAVE_ADDR  = 7'h53,
  parameter int         NUM_ENTRIES = 4,
  parameter int         IDX_W       = 8,
  parameter bit         AUTO_START  = 1'b1
) (
  input logic                  clk_clk,
  input logic                  reset_reset,
  i2c_init_sequencer_if.master bus
);
  localparam int               QDIV     = CLK_HZ / (4 * I2C_HZ);
  localparam int               CW       = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0]    QMAX     = CW'(QDIV - 1);
  localparam logic [CW-1:0]    QONE     = CW'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SHIFT = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_GAP   = 3'd5,
    S_NEXT  = 3'd6,
    S_DONE  = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    qcnt_q, qcnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic [7:0]       sh_q, sh_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;
  logic             pend_q, pend_d;
  logic             fail_q, fail_d;
  logic             sda_oe_q, scl_oe_q;
  logic             sda_int_s, scl_int_s, hold_s, tick_s, run_s;

  // State register plus the registered pad arbiter
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= S_IDLE;
      qcnt_q   <= {CW{1'b0}};
      qtr_q    <= 2'd0;
      bit_q    <= 3'd0;
      byte_q   <= 2'd0;
      sh_q     <= 8'd0;
      idx_q    <= {IDX_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
      pend_q   <= AUTO_START;
      fail_q   <= 1'b0;
      sda_oe_q <= 1'b0;
      scl_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      nack_q   <= nack_d;
      pend_q   <= pend_d;
      fail_q   <= fail_d;
      sda_oe_q <= busy_q ? sda_int_s : bus.nios_sda_oe;
      scl_oe_q <= busy_q ? scl_int_s : bus.nios_scl_oe;
    end
  end

  // Next-state, quarter timing and internal line drive
  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    sh_d      = sh_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = done_q;
    nack_d    = nack_q;
    fail_d    = fail_q;
    sda_int_s = 1'b0;
    scl_int_s = 1'b0;
    pend_d    = pend_q | (bus.start & ~busy_q);
`ifdef CLOCK_STRETCH_EN
    hold_s    = ((state_q == S_SHIFT) || (state_q == S_ACK)) && (qtr_q == 2'd2) && !bus.scl_in;
`else
    hold_s    = 1'b0;
`endif
    tick_s    = (qcnt_q == QMAX) && !hold_s;
    run_s     = (state_q != S_IDLE) && (state_q != S_NEXT) && (state_q != S_DONE);

    // The counter parks on its last value while a stretched SCL is held low
    if (!run_s) begin
      qcnt_d = {CW{1'b0}};
    end else if (tick_s) begin
      qcnt_d = {CW{1'b0}};
    end else if (qcnt_q != QMAX) begin
      qcnt_d = qcnt_q + QONE;
    end else begin
      qcnt_d = qcnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q && !bus.nios_sda_oe && !bus.nios_scl_oe) begin
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          nack_d  = 1'b0;
          fail_d  = 1'b0;
          idx_d   = {IDX_W{1'b0}};
          qtr_d   = 2'd0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        sda_int_s = qtr_q[0];
        if (tick_s && (qtr_q == 2'd1)) begin
          qtr_d   = 2'd0;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
          sh_d    = {SLAVE_ADDR, 1'b0};
          state_d = S_SHIFT;
        end else if (tick_s) begin
          qtr_d = qtr_q + 2'd1;
        end else begin
          qtr_d = qtr_q;
        end
      end
      S_SHIFT: begin
        scl_int_s = ~qtr_q[1];
        sda_int_s = ~sh_q[7];
        if (tick_s && (qtr_q == 2'd3)) begin
          qtr_d   = 2'd0;
          sh_d    = {sh_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? S_ACK : S_SHIFT;
        end else if (tick_s) begin
          qtr_d = qtr_q + 2'd1;
        end else begin
          qtr_d = qtr_q;
        end
      end
      S_ACK: begin
        scl_int_s = ~qtr_q[1];
        if (tick_s && (qtr_q == 2'd3)) begin
          qtr_d = 2'd0;
          if (bus.sda_in) begin
            fail_d  = 1'b1;
            state_d = S_STOP;
          end else if (byte_q == 2'd2) begin
            state_d = S_STOP;
          end else begin
            byte_d  = byte_q + 2'd1;
            sh_d    = (byte_q == 2'd0) ? bus.tbl_reg : bus.tbl_data;
            state_d = S_SHIFT;
          end
        end else if (tick_s) begin
          qtr_d = qtr_q + 2'd1;
        end else begin
          qtr_d = qtr_q;
        end
      end
      S_STOP: begin
        // SDA held low through the SCL rise; it is released on leaving STOP
        sda_int_s = 1'b1;
        scl_int_s = (qtr_q == 2'd0);
        if (tick_s && (qtr_q == 2'd1)) begin
          qtr_d = 2'd0;
          if (fail_q) begin
            nack_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end else if (tick_s) begin
          qtr_d = qtr_q + 2'd1;
        end else begin
          qtr_d = qtr_q;
        end
      end
      S_GAP: begin
        if (tick_s) begin
          qtr_d   = qtr_q + 2'd1;
          state_d = (qtr_q == 2'd3) ? S_NEXT : S_GAP;
        end else begin
          qtr_d = qtr_q;
        end
      end
      S_NEXT: begin
        qtr_d = 2'd0;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_START;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.tbl_idx  = idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.nack_err = nack_q;
  assign bus.sda_oe   = sda_oe_q;
  assign bus.scl_oe   = scl_oe_q;
endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Scoreboard bench: a pad-level bus decoder checks decoded START/byte/STOP events against
// frames predicted from the table; a small slave model ACKs, NACKs or stretches SCL.
module tb_i2c_init_sequencer;
  localparam int         CLK_HZ   = 1600000;
  localparam int         I2C_HZ   = 100000;
  localparam int         QDIV     = CLK_HZ / (4 * I2C_HZ);
  localparam int         NENT     = 2;
  localparam logic [6:0] SADDR    = 7'h53;
  localparam int         EV_START = 256;
  localparam int         EV_STOP  = 257;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   exp_q[$];
  logic [7:0] rom_reg [NENT];
  logic [7:0] rom_data[NENT];
  logic slave_low   = 1'b0;
  logic stretch_low = 1'b0;
  bit   nack_mode   = 1'b0;
  bit   stretch_arm = 1'b0;
  bit   skip_period = 1'b0;
  int   max_period  = 0;
  int   sbit = 0, sbyte = 0, scnt = 0;

  i2c_init_sequencer_if #(.IDX_W(8)) bus ();

  i2c_init_sequencer #(
    .CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ), .SLAVE_ADDR(SADDR),
    .NUM_ENTRIES(NENT), .IDX_W(8), .AUTO_START(1'b1)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.sda_in = ~(bus.sda_oe | slave_low);
  assign bus.scl_in = ~(bus.scl_oe | stretch_low);

  always_comb begin
    bus.tbl_reg  = 8'h00;
    bus.tbl_data = 8'h00;
    if (int'(bus.tbl_idx) < NENT) begin
      bus.tbl_reg  = rom_reg[int'(bus.tbl_idx)];
      bus.tbl_data = rom_data[int'(bus.tbl_idx)];
    end
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic sb_check(input int got);
    int exp;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL bus_event: got 0x%0h with nothing expected (0x100=START 0x101=STOP)", got);
    end else begin
      exp = exp_q.pop_front();
      if (got != exp) begin
        fails++;
        $display("FAIL bus_event: got 0x%0h, required 0x%0h (0x100=START 0x101=STOP)", got, exp);
      end
    end
  endtask

  // Reference: every entry is START, address+W, register, data, STOP; a NACK ends after the address.
  task automatic push_run(input bit nack);
    for (int i = 0; i < NENT; i++) begin
      exp_q.push_back(EV_START);
      exp_q.push_back(int'(SADDR) * 2);
      if (nack) begin
        exp_q.push_back(EV_STOP);
        break;
      end
      exp_q.push_back(int'(rom_reg[i]));
      exp_q.push_back(int'(rom_data[i]));
      exp_q.push_back(EV_STOP);
    end
  endtask

  // Monitor: decode pad levels into START/STOP/byte events and check SCL period
  logic       prev_sda = 1'b1, prev_scl = 1'b1;
  bit         synced = 1'b0;
  int         bitcnt = 0, cyc = 0, last_rise = 0, period;
  logic [7:0] shv = 8'h00;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      synced = 1'b0;
    end else if (prev_scl && bus.scl_in && prev_sda && !bus.sda_in) begin
      sb_check(EV_START);
      synced = 1'b1;
      bitcnt = 0;
    end else if (synced && prev_scl && bus.scl_in && !prev_sda && bus.sda_in) begin
      sb_check(EV_STOP);
      synced = 1'b0;
    end else if (synced && !prev_scl && bus.scl_in) begin
      period = cyc - last_rise;
      if (bitcnt != 0) begin
        if (period > max_period) max_period = period;
        if (!skip_period) check("scl_period", period, 4 * QDIV);
      end
      last_rise = cyc;
      if (bitcnt < 8) shv = {shv[6:0], bus.sda_in};
      bitcnt++;
      if (bitcnt == 8) sb_check(int'(shv));
      else if (bitcnt == 9) bitcnt = 0;
    end
    prev_sda = bus.sda_in;
    prev_scl = bus.scl_in;
  end

  // Slave model: ACK in the ninth clock, optional long stretch on bit 3 of the register byte
  logic sprev_sda = 1'b1, sprev_scl = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      slave_low   <= 1'b0;
      stretch_low <= 1'b0;
      sbit  = 0;
      sbyte = 0;
    end else begin
      if (sprev_scl && bus.scl_in && sprev_sda && !bus.sda_in) begin
        sbit  = 0;
        sbyte = 0;
      end else if (!sprev_scl && bus.scl_in) begin
        sbit++;
      end else if (sprev_scl && !bus.scl_in) begin
        slave_low <= (sbit == 8) && !nack_mode;
        if (sbit == 9) begin
          sbit = 0;
          sbyte++;
        end
        if (stretch_arm && sbyte == 1 && sbit == 3) begin
          stretch_low <= 1'b1;
          scnt = 300;
          stretch_arm = 1'b0;
        end
      end
      if (stretch_low && !bus.scl_oe) begin
        scnt--;
        if (scnt <= 0) stretch_low <= 1'b0;
      end
    end
    sprev_sda = bus.sda_in;
    sprev_scl = bus.scl_in;
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_run(input string name);
    int n;
    n = 0;
    while (!bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_seen"}, int'(bus.busy), 1);
    n = 0;
    while (bus.busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_finished"}, int'(bus.busy), 0);
    repeat (6) @(negedge clk);
    check({name, "_all_events_seen"}, exp_q.size(), 0);
  endtask

  task automatic check_status(input string name, input int d, input int nk, input int idx);
    check({name, "_done"}, int'(bus.done), d);
    check({name, "_nack_err"}, int'(bus.nack_err), nk);
    check({name, "_tbl_idx"}, int'(bus.tbl_idx), idx);
    check({name, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    int   n;
    logic v;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.nios_sda_oe = 1'b0;
    bus.nios_scl_oe = 1'b0;
    rom_reg[0] = 8'h2D; rom_data[0] = 8'h08;
    rom_reg[1] = 8'h31; rom_data[1] = 8'h0B;
    repeat (3) @(negedge clk);
    check("rst_sda_oe", int'(bus.sda_oe), 0);
    check("rst_scl_oe", int'(bus.scl_oe), 0);
    check_status("rst", 0, 0, 0);

    push_run(1'b0);
    rst = 1'b0;
    wait_run("auto");
    check_status("auto", 1, 0, NENT - 1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NENT; i++) begin
        rom_reg[i]  = 8'($urandom);
        rom_data[i] = 8'($urandom);
      end
      push_run(1'b0);
      pulse_start();
      if (r == 1) begin
        repeat (200) @(negedge clk);
        pulse_start();
      end
      wait_run("rand");
      check_status("rand", 1, 0, NENT - 1);
      repeat (30) @(negedge clk);
      check("start_while_busy_ignored", int'(bus.busy), 0);
    end

    nack_mode = 1'b1;
    push_run(1'b1);
    pulse_start();
    wait_run("nack");
    check_status("nack", 0, 1, 0);
    nack_mode = 1'b0;

    bus.nios_scl_oe = 1'b1;
    pulse_start();
    v = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.nios_sda_oe = v;
      @(negedge clk);
      check("passthru_sda", int'(bus.sda_oe), int'(v));
      check("passthru_scl", int'(bus.scl_oe), 1);
      check("held_busy", int'(bus.busy), 0);
      v = 1'($urandom_range(0, 1));
    end
    bus.nios_sda_oe = 1'b0;
    @(negedge clk);
    push_run(1'b0);
    bus.nios_scl_oe = 1'b0;
    n = 0;
    while (!bus.busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("busy_within_2", int'(n <= 2), 1);
    wait_run("nios");
    check_status("nios", 1, 0, NENT - 1);

    push_run(1'b0);
    pulse_start();
    n = 0;
    while (!(sbyte == 2 && sbit == 3) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reached_data_byte", int'(n < 5000), 1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_sda_oe", int'(bus.sda_oe), 0);
    check("midrst_scl_oe", int'(bus.scl_oe), 0);
    check("midrst_busy", int'(bus.busy), 0);
    repeat (2) @(negedge clk);
    push_run(1'b0);
    rst = 1'b0;
    pulse_start();
    wait_run("after_rst");
    check_status("after_rst", 1, 0, NENT - 1);

`ifdef CLOCK_STRETCH_EN
    skip_period = 1'b1;
    max_period  = 0;
    stretch_arm = 1'b1;
    push_run(1'b0);
    pulse_start();
    wait_run("stretch");
    check_status("stretch", 1, 0, NENT - 1);
    check("stretch_long_bit", int'(max_period >= 300), 1);
    skip_period = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Hardware I2C master that writes a table of (register, value) pairs to one slave after reset or on request, e.g. to configure the on-board accelerometer before software runs.
- Shares the open-drain I2C pins with the Nios i2c_0 core. The sequencer owns the bus while busy; i2c_0 owns it otherwise.
- Sits in the top level, between the nios system's i2c_0 oe outputs and the SDA/SCL pads.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- I2C_HZ, 100000, SCL rate. Quarter-bit divider QDIV = CLK_HZ/(4*I2C_HZ), 125 at defaults.
- SLAVE_ADDR, 7'h53, 7-bit slave address.
- NUM_ENTRIES, 4, number of table entries; range 1..256.
- IDX_W, 8, width of tbl_idx; must satisfy 2^IDX_W >= NUM_ENTRIES.
- AUTO_START, 1, if 1 a run is requested automatically on the first cycle after reset.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse requesting a run.
- tbl_idx  out  IDX_W  current table index, read by an external combinational ROM.
- tbl_reg  in  8  register address for tbl_idx.
- tbl_data  in  8  data byte for tbl_idx.
- busy  out  1  high while the sequencer owns the bus.
- done  out  1  high after a full run in which every byte was ACKed.
- nack_err  out  1  sticky flag: a NACK was received in the last run.
- sda_in  in  1  SDA pad level.
- scl_in  in  1  SCL pad level.
- nios_sda_oe  in  1  i2c_0 SDA pull-low request.
- nios_scl_oe  in  1  i2c_0 SCL pull-low request.
- sda_oe  out  1  SDA pad pull-low; 1 drives low.
- scl_oe  out  1  SCL pad pull-low; 1 drives low.

Behaviour:
- Reset:
  - All state returns to IDLE.
  - Outputs: busy=0, done=0, nack_err=0, tbl_idx=0. Internal oe=0, so sda_oe/scl_oe follow the nios inputs.
  - The quarter counter clears.
  - Reset mid-transfer releases both lines on the next cycle; no STOP is generated.
- Request latch:
  - A start pulse, or the AUTO_START request, sets a pending bit.
  - The pending bit is consumed when state=IDLE and nios_sda_oe=0 and nios_scl_oe=0.
  - While i2c_0 holds either line, the request stays pending.
  - start while busy is ignored.
- Run entry: on consume, busy=1, done=0, nack_err=0, tbl_idx=0.
- Arbiter, registered (one cycle):
  - busy=1: sda_oe/scl_oe = sequencer internal.
  - busy=0: sda_oe/scl_oe = nios_sda_oe/nios_scl_oe.
- Timing: a tick occurs every QDIV clocks. Each bit takes 4 ticks:
  - Q0: SCL low, drive SDA.
  - Q1: SCL low.
  - Q2: release SCL.
  - Q3: SCL high, sample sda_in at the end of Q3.
- Per-entry frame: START, then byte SLAVE_ADDR<<1 (R/W=0), ACK, tbl_reg, ACK, tbl_data, ACK, STOP. Bytes are sent MSB first.
- States:
  - IDLE: wait for the pending request.
  - START: SDA falls while SCL is high; 2 ticks.
  - SHIFT: 8 bits.
  - ACK: release SDA; sample. sda_in=0 means ACK.
  - STOP: SCL high, then SDA rises; 2 ticks.
  - GAP: bus free for 4 ticks.
  - NEXT: move to the next entry or finish.
  - DONE.
- ACK → next byte; after the data-byte ACK → STOP.
- NACK on any byte → STOP, then nack_err=1, busy=0, done=0, IDLE; tbl_idx holds the failing entry.
- NEXT:
  - If tbl_idx = NUM_ENTRIES-1: done=1, busy=0, IDLE. tbl_idx holds its value and is not wrapped.
  - Otherwise tbl_idx+1 → START.
- tbl_reg/tbl_data are sampled when each byte is loaded into the shift register; the ROM must be stable from the tbl_idx change onward.
- done stays high until the next run is consumed or reset.

Optional Feature:
- CLOCK_STRETCH_EN defined:
  - In Q2, the quarter counter holds until scl_in=1, so a slave may stretch the clock indefinitely.
  - Q3 timing starts from the first cycle scl_in=1.
- Not defined: fixed timing; scl_in is ignored.

Test Plan:
- Reset, nios oe=0 → sda_oe=scl_oe=0, busy=0, done=0, nack_err=0, tbl_idx=0.
- AUTO_START=1, NUM_ENTRIES=2, table {0x2D:0x08, 0x31:0x0B}, slave model ACKs all bytes:
  - Bytes decoded 0xA6,0x2D,0x08 then 0xA6,0x31,0x0B, each frame with START/STOP.
  - SCL period = 4*QDIV clocks.
  - done=1, busy=0, tbl_idx=1.
- Slave NACKs the address byte → STOP issued, nack_err=1, done=0, tbl_idx=0, busy=0.
- nios_scl_oe=1 when start is pulsed → busy stays 0 and pass-through continues. Release nios_scl_oe → busy=1 within 2 cycles.
- CLOCK_STRETCH_EN: slave holds SCL low 300 clocks on bit 3 of the register byte → no sample before scl_in rises; byte still correct.
- reset_reset asserted mid-data byte → sda_oe=scl_oe=0 on the next cycle, busy=0. A new start runs the full sequence from tbl_idx=0.
